// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with PC, imem req/ack and valid/ready output; IFETCH_PREFETCH_EN enables a 2-entry prefetch buffer
module instr_fetch #(
  parameter int              AW       = 16,
  parameter int              IW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_word,
  output logic [AW-1:0] inst_pc,
  output logic [2:0]    opcode,
  output logic          funct,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  // pc is the next address to request; drop_addr holds the old address of a request
  // that a redirect has orphaned so the bus stays stable until its ack arrives
  logic [AW-1:0] pc, pc_nx;
  logic          drop, drop_nx;
  logic [AW-1:0] drop_addr, drop_addr_nx;

  assign imem_addr = drop ? drop_addr : pc;
  assign opcode    = inst_word[IW-1:IW-3];
  assign funct     = inst_word[0];

`ifdef IFETCH_PREFETCH_EN

  logic          req_q, req_nx;
  logic [1:0]    cnt, cnt_nx;
  logic          head, head_nx;
  logic [IW-1:0] fifo_word [2];
  logic [AW-1:0] fifo_pc   [2];
  logic          push, pop;

  assign imem_req   = req_q;
  assign inst_valid = (cnt != 2'd0);
  assign inst_word  = fifo_word[head];
  assign inst_pc    = fifo_pc[head];
  assign push       = req_q & imem_ack & ~drop & ~redirect;
  assign pop        = inst_valid & inst_ready;

  // Next-state: keep (entries + outstanding) <= 2; redirect flushes and retargets the PC
  always_comb begin
    cnt_nx       = cnt + {1'b0, push} - {1'b0, pop};
    head_nx      = head ^ pop;
    pc_nx        = push ? pc + AW'(1) : pc;
    drop_nx      = drop;
    drop_addr_nx = drop_addr;
    req_nx       = req_q;
    if (req_q && imem_ack) begin
      drop_nx = 1'b0;
      req_nx  = fetch_en && (cnt_nx < 2'd2);
    end else if (!req_q) begin
      req_nx  = fetch_en && (cnt_nx < 2'd2);
    end
    if (redirect) begin
      pc_nx   = redirect_pc;
      cnt_nx  = 2'd0;
      head_nx = 1'b0;
      if (req_q && !imem_ack) begin
        req_nx = 1'b1;
        if (!drop) begin
          drop_nx      = 1'b1;
          drop_addr_nx = pc;
        end
      end else if (req_q) begin
        req_nx = 1'b1;
      end else begin
        req_nx = fetch_en;
      end
    end
  end

  // State registers and buffer writes into the tail slot
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      cnt       <= 2'd0;
      head      <= 1'b0;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      drop_addr <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      req_q     <= req_nx;
      cnt       <= cnt_nx;
      head      <= head_nx;
      pc        <= pc_nx;
      drop      <= drop_nx;
      drop_addr <= drop_addr_nx;
      if (push) begin
        fifo_word[head ^ cnt[0]] <= imem_rdata;
        fifo_pc[head ^ cnt[0]]   <= pc;
      end
    end
  end

`else

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] word_q, word_nx;
  logic [AW-1:0] ipc_q, ipc_nx;

  assign imem_req   = (state == REQ);
  assign inst_valid = (state == FULL);
  assign inst_word  = word_q;
  assign inst_pc    = ipc_q;

  // Next-state: one request at a time, single output buffer, redirect overrides all
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_nx      = drop;
    drop_addr_nx = drop_addr;
    word_nx      = word_q;
    ipc_nx       = ipc_q;
    case (state)
      IDLE: if (fetch_en) state_nx = REQ;
      REQ: begin
        if (imem_ack) begin
          drop_nx = 1'b0;
          if (drop || redirect) begin
            state_nx = (fetch_en || redirect) ? REQ : IDLE;
          end else begin
            word_nx  = imem_rdata;
            ipc_nx   = pc;
            pc_nx    = pc + AW'(1);
            state_nx = FULL;
          end
        end else if (redirect && !drop) begin
          drop_nx      = 1'b1;
          drop_addr_nx = pc;
        end
      end
      FULL: if (inst_ready) state_nx = fetch_en ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
    if (redirect) begin
      pc_nx = redirect_pc;
      if (state != REQ) state_nx = fetch_en ? REQ : IDLE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      drop_addr <= '0;
      word_q    <= '0;
      ipc_q     <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop      <= drop_nx;
      drop_addr <= drop_addr_nx;
      word_q    <= word_nx;
      ipc_q     <= ipc_nx;
    end
  end

`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (default build)
module tb_instr_fetch;
  localparam logic [15:0] RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] inst_word;
  logic [15:0] inst_pc;
  logic [2:0]  opcode;
  logic        funct;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 0;
  int mcnt = 0;
  logic [15:0] exp_q[$];
  int          hs_q[$];
  bit          pr_hold = 0;
  bit          pv_hold = 0;
  logic [15:0] pr_addr, pv_word, pv_pc;

  instr_fetch #(.AW(16), .IW(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word), .inst_pc(inst_pc),
    .opcode(opcode), .funct(funct), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: address as data, with one opcode/funct test pattern
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0030) ? 16'hE001 : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: ack after 'lat' wait cycles of a held request
  always @(negedge clk) begin
    if (imem_req) begin
      if (mcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        mcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      mcnt     = 0;
    end
  end

  // Per-cycle checker against the expected fetch stream and handshake rules
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pr_hold = 0;
      pv_hold = 0;
    end else begin
      if (imem_req && inst_valid) chk("req_while_valid", 32'(imem_req & inst_valid), 32'd0);
      if (pr_hold) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_stable", 32'(imem_addr), 32'(pr_addr));
      end
      if (pv_hold) begin
        chk("valid_held", 32'(inst_valid), 32'd1);
        chk("word_stable", 32'(inst_word), 32'(pv_word));
        chk("pc_stable", 32'(inst_pc), 32'(pv_pc));
      end
      if (inst_valid) begin
        chk("opcode_slice", 32'(opcode), 32'(inst_word[15:13]));
        chk("funct_slice", 32'(funct), 32'(inst_word[0]));
      end
      if (inst_valid && inst_ready) begin
        chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("inst_pc", 32'(inst_pc), 32'(e));
          chk("inst_word", 32'(inst_word), 32'(mem_word(e)));
        end
        hs_q.push_back(cyc);
      end
      pr_hold = imem_req && !imem_ack;
      pr_addr = imem_addr;
      pv_hold = inst_valid && !inst_ready && !redirect;
      pv_word = inst_word;
      pv_pc   = inst_pc;
    end
  end

  task automatic check_reset_vals(input string p);
    chk({p, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({p, "_imem_addr"}, 32'(imem_addr), 32'(RPC));
    chk({p, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({p, "_inst_word"}, 32'(inst_word), 32'd0);
    chk({p, "_inst_pc"}, 32'(inst_pc), 32'd0);
    chk({p, "_opcode"}, 32'(opcode), 32'd0);
    chk({p, "_funct"}, 32'(funct), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_vals("rst");
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk); #2;
      if (inst_valid) break;
    end
    if (i == max) chk({name, "_valid_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  // Runs until every expected word was consumed, then stops fetching at the next edge
  task automatic wait_drain(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #2;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    fetch_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0;
    int waits;

    do_reset();

    // Sequential fetch from RESET_PC, zero-wait memory, one word every 2 cycles
    hs_q.delete();
    exp_q = '{16'h0010, 16'h0011, 16'h0012};
    lat = 0;
    @(negedge clk); fetch_en = 1'b1; c0 = cyc;
    @(negedge clk); #2;
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", 32'(imem_addr), 32'h0010);
    wait_drain("t1", 40);
    chk("t1_hs_count", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() >= 3) begin
      chk("t1_first_latency", 32'(hs_q[0] - c0), 32'd2);
      chk("t1_gap1", 32'(hs_q[1] - hs_q[0]), 32'd2);
      chk("t1_gap2", 32'(hs_q[2] - hs_q[1]), 32'd2);
    end

    // 3 wait states then 4 cycles of back-pressure; word held, no second request
    exp_q = '{16'h0013};
    @(negedge clk); lat = 3; inst_ready = 1'b0; fetch_en = 1'b1;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (imem_req && imem_ack) break;
      if (imem_req) waits++;
    end
    chk("t2_wait_cycles", 32'(waits), 32'd3);
    wait_valid("t2", 10);
    chk("t2_inst_pc", 32'(inst_pc), 32'h0013);
    chk("t2_inst_word", 32'(inst_word), 32'h0013);
    repeat (4) @(negedge clk);
    #2;
    chk("t2_still_valid", 32'(inst_valid), 32'd1);
    chk("t2_no_second_req", 32'(imem_req), 32'd0);
    @(negedge clk); inst_ready = 1'b1; #2;
    wait_drain("t2", 10);

    // Redirect while the request to 0x0012 waits; its word must never appear
    do_reset();
    exp_q = '{16'h0010, 16'h0011, 16'h0040};
    @(negedge clk); lat = 2; fetch_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (imem_req && imem_addr == 16'h0012) break;
    end
    chk("t3_at_0012", 32'(imem_addr), 32'h0012);
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0040; #2;
    chk("t3_no_ack_yet", 32'(imem_ack), 32'd0);
    @(negedge clk); redirect = 1'b0; #2;
    chk("t3_old_addr_held", 32'(imem_addr), 32'h0012);
    chk("t3_valid_cleared", 32'(inst_valid), 32'd0);
    @(negedge clk); #2;
    chk("t3_new_req", 32'(imem_req), 32'd1);
    chk("t3_new_addr", 32'(imem_addr), 32'h0040);
    wait_drain("t3", 20);

    // Redirect in the same cycle as the ack of 0x0005
    exp_q = '{16'h0050};
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0005;
    @(negedge clk); redirect = 1'b0; fetch_en = 1'b1; lat = 0;
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0050; #2;
    chk("t4_ack_addr", 32'(imem_addr), 32'h0005);
    chk("t4_ack_seen", 32'(imem_ack), 32'd1);
    @(negedge clk); redirect = 1'b0; #2;
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_req_addr", 32'(imem_addr), 32'h0050);
    chk("t4_discarded", 32'(inst_valid), 32'd0);
    wait_drain("t4", 20);

    // PC wrap from 0xFFFF to 0x0000; redirect from idle issues next cycle
    exp_q = '{16'hFFFF, 16'h0000};
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'hFFFF; fetch_en = 1'b1;
    @(negedge clk); redirect = 1'b0; #2;
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_req_addr", 32'(imem_addr), 32'hFFFF);
    wait_drain("t5", 20);

    // opcode/funct of 0xE001, then reset in the middle of a request
    exp_q = '{16'h0030};
    @(negedge clk); lat = 3; inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0030; fetch_en = 1'b1;
    @(negedge clk); redirect = 1'b0;
    wait_valid("t6", 20);
    chk("t6_inst_word", 32'(inst_word), 32'hE001);
    chk("t6_opcode", 32'(opcode), 32'd7);
    chk("t6_funct", 32'(funct), 32'd1);
    chk("t6_inst_pc", 32'(inst_pc), 32'h0030);
    @(negedge clk); inst_ready = 1'b1; #2;
    @(negedge clk); #2;
    chk("t6_req_next", 32'(imem_req), 32'd1);
    chk("t6_req_next_addr", 32'(imem_addr), 32'h0031);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    check_reset_vals("t6_midreq_rst");
    rst = 1'b0; fetch_en = 1'b0;
    repeat (2) @(negedge clk);

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle-decode CPU: holds the program counter, requests instruction words from instruction memory over a req/ack handshake, and presents each fetched word to the control decoder and datapath through a valid/ready interface. It sits directly upstream of the control decoder, to which it supplies the 3-bit opcode and the 1-bit funct field. It accepts PC redirects (taken beq, jal, jr) from the execute logic.

## Interface
- AW, 16, PC and instruction-memory address width (word-addressed)
- IW, 16, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  fetch permitted; sampled every cycle
- imem_req  out  1  instruction memory request
- imem_addr  out  AW  request address; stable while imem_req high
- imem_ack  in  1  memory returns imem_rdata this cycle; only meaningful while imem_req high
- imem_rdata  in  IW  instruction word, valid with imem_ack
- inst_valid  out  1  inst_word/inst_pc/opcode/funct valid
- inst_ready  in  1  decoder consumes the word when inst_valid & inst_ready
- inst_word  out  IW  fetched instruction
- inst_pc  out  AW  address the word was fetched from
- opcode  out  3  inst_word[IW-1:IW-3], drives decoder opcode input
- funct  out  1  inst_word[0], drives decoder funct input
- redirect  in  1  load redirect_pc, flush buffered/in-flight words
- redirect_pc  in  AW  new fetch address

## Operation
- FSM states: IDLE, REQ, FULL.
- IDLE: imem_req=0. fetch_en=1 -> REQ next cycle.
- REQ: imem_req=1, imem_addr=PC. On imem_ack: capture imem_rdata and PC into the output buffer, PC <= PC+1, -> FULL. Request held until ack; never withdrawn.
- FULL: inst_valid=1, outputs stable. On inst_ready: -> REQ if fetch_en, else IDLE.
- PC arithmetic: PC+1 modulo 2^AW; all-ones wraps to 0 silently.
- opcode and funct are pure slices of the registered inst_word; no decoding here.
- fetch_en low in REQ: outstanding request completes normally, then FULL; no further requests until fetch_en returns.
- redirect (highest priority, any state): PC <= redirect_pc next cycle; output buffer invalidated (inst_valid=0 next cycle).
  - In REQ without ack that cycle: set drop flag; request stays asserted at old address until ack; that response is discarded (no buffer write, no PC increment); then new request to redirect_pc.
  - In REQ with ack that same cycle: response discarded; next cycle REQ at redirect_pc.
  - In FULL with inst_valid & inst_ready same cycle: handshake counts as consumed; buffer still cleared.
  - In IDLE/FULL: -> REQ if fetch_en else IDLE.
- Back-to-back redirects: last one wins.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_word=0, inst_pc=0, opcode=0, funct=0, state IDLE, drop flag 0.
- fetch_en seen in cycle N (IDLE) -> imem_req high in N+1.
- imem_ack in cycle M -> inst_valid high in M+1 with that word.
- Zero-wait memory, inst_ready tied high: one instruction per 2 cycles (base build).
- Redirect in cycle R with no outstanding request -> imem_req at redirect_pc in R+1.
- rst mid-operation overrides everything; in-flight request abandoned, memory must tolerate req dropping on reset.

## Configuration
- IFETCH_PREFETCH_EN defined: output buffer becomes 2-entry FIFO; new request issued whenever (entries + outstanding) < 2, including while inst_valid high; sustained 1 instruction/cycle with zero-wait memory and inst_ready high. Redirect flushes both entries; drop flag still applies to the outstanding request.
- Undefined: single-entry buffer and IDLE/REQ/FULL behaviour above; no request while inst_valid high.

## Test plan
- Reset, RESET_PC=0x0010, fetch_en=1, zero-wait memory returning addr as data -> inst_pc 0x0010,0x0011,0x0012 in order; base build valid every 2nd cycle, prefetch build every cycle.
- Memory acks after 3 cycles, inst_ready low 4 cycles -> imem_addr stable for the 3 wait cycles; inst_word held unchanged until ready; no second request in base build.
- redirect=1, redirect_pc=0x0040 while request to 0x0012 outstanding, ack 2 cycles later -> word from 0x0012 never presented; next inst_pc=0x0040.
- redirect on same cycle as ack of 0x0005 -> 0x0005 discarded; next request address = redirect_pc.
- PC=0xFFFF fetch -> inst_pc 0xFFFF then 0x0000.
- Instruction 0xE001 fetched -> opcode=3'b111, funct=1; rst asserted mid-REQ -> next cycle all outputs at reset values.
